text_pixel_serializer: RTL and testbench

- Downstream consumer of the text pixel generator.
- Takes the generator's 8-pixel character row bytes (cur_pixels) and shifts them out one pixel per pixel-clock-enable during the display active area.
- Drives the generator's toggle_restart and toggle_next request lines, prefetching one character ahead so the shifter never starves.
- Output is a per-pixel on/off bit plus fixed foreground/background RGB for the video output mux.

---
 rtl/text_pixel_serializer.sv | 123 ++++++++++++
 tb/tb_text_pixel_serializer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_pixel_serializer.sv
// Serializes the text generator's 8-pixel row bytes onto the pixel stream,
// prefetching one character ahead via the generator's toggle handshake.
module text_pixel_serializer #(
  parameter int unsigned FETCH_LATENCY = 4,
  parameter logic [23:0] FG_COLOR      = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR      = 24'h000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        pix_ce,
  input  logic        de,
  output logic        toggle_restart,
  output logic        toggle_next,
  input  logic [7:0]  cur_pixels,
  output logic        pixel_on,
  output logic [23:0] rgb,
  output logic        underrun
);

  localparam logic [3:0] FETCH_LAT = 4'(FETCH_LATENCY);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  holding_q, holding_d;
  logic        hold_valid_q, hold_valid_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  fetch_cnt_q, fetch_cnt_d;
  logic        toggle_restart_q, toggle_restart_d;
  logic        toggle_next_q, toggle_next_d;
  logic        pixel_on_q, pixel_on_d;
  logic        underrun_q, underrun_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      shift_q          <= 8'h00;
      holding_q        <= 8'h00;
      hold_valid_q     <= 1'b0;
      bit_cnt_q        <= 3'd0;
      fetch_cnt_q      <= 4'd0;
      toggle_restart_q <= 1'b0;
      toggle_next_q    <= 1'b0;
      pixel_on_q       <= 1'b0;
      underrun_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      shift_q          <= shift_d;
      holding_q        <= holding_d;
      hold_valid_q     <= hold_valid_d;
      bit_cnt_q        <= bit_cnt_d;
      fetch_cnt_q      <= fetch_cnt_d;
      toggle_restart_q <= toggle_restart_d;
      toggle_next_q    <= toggle_next_d;
      pixel_on_q       <= pixel_on_d;
      underrun_q       <= underrun_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    shift_d          = shift_q;
    holding_d        = holding_q;
    hold_valid_d     = hold_valid_q;
    bit_cnt_d        = bit_cnt_q;
    fetch_cnt_d      = fetch_cnt_q;
    toggle_restart_d = toggle_restart_q;
    toggle_next_d    = toggle_next_q;
    pixel_on_d       = pixel_on_q;
    underrun_d       = underrun_q;

    if (fetch_cnt_q != 4'd0) begin
      fetch_cnt_d = fetch_cnt_q - 4'd1;
    end
    if (fetch_cnt_q == 4'd1) begin
      holding_d    = cur_pixels;
      hold_valid_d = 1'b1;
    end

    // frame_start outranks any pixel step in the same cycle
    if (frame_start) begin
      state_d          = RUN;
      toggle_restart_d = ~toggle_restart_q;
      fetch_cnt_d      = FETCH_LAT;
      hold_valid_d     = 1'b0;
      bit_cnt_d        = 3'd0;
    end else if (state_q == RUN && pix_ce) begin
      if (de) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd0) begin
          // every load requests the next character, even on underrun,
          // so the generator's column pointer stays aligned
          toggle_next_d = ~toggle_next_q;
          hold_valid_d  = 1'b0;
          fetch_cnt_d   = FETCH_LAT;
          if (hold_valid_q) begin
            shift_d    = {holding_q[6:0], 1'b0};
            pixel_on_d = holding_q[7];
          end else begin
            shift_d    = 8'h00;
            pixel_on_d = 1'b0;
            underrun_d = 1'b1;
          end
        end else begin
          pixel_on_d = shift_q[7];
          shift_d    = {shift_q[6:0], 1'b0};
        end
      end else begin
        pixel_on_d = 1'b0;
        bit_cnt_d  = 3'd0;
      end
    end
  end

  assign toggle_restart = toggle_restart_q;
  assign toggle_next    = toggle_next_q;
  assign pixel_on       = pixel_on_q;
  assign underrun       = underrun_q;
  assign rgb            = pixel_on_q ? FG_COLOR : BG_COLOR;

endmodule

// File: tb/tb_text_pixel_serializer.sv
// Directed bench for text_pixel_serializer with a behavioural text generator
// model driving cur_pixels from the toggle handshake.
module tb_text_pixel_serializer;

  localparam logic [23:0] FG   = 24'hFFFFFF;
  localparam logic [23:0] BG   = 24'h000000;
  localparam logic [23:0] FG_S = 24'hF0E0D0;
  localparam logic [23:0] BG_S = 24'h102030;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, frame_start, pix_ce, de;
  logic        toggle_restart, toggle_next, pixel_on, underrun;
  logic [7:0]  cur_pixels;
  logic [23:0] rgb;

  logic        frame_start_s, pix_ce_s, de_s;
  logic        toggle_restart_s, toggle_next_s, pixel_on_s, underrun_s;
  logic [23:0] rgb_s;

  int n_cmp = 0;
  int n_bad = 0;

  text_pixel_serializer #(.FETCH_LATENCY(4)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .pix_ce(pix_ce),
    .de(de), .toggle_restart(toggle_restart), .toggle_next(toggle_next),
    .cur_pixels(cur_pixels), .pixel_on(pixel_on), .rgb(rgb), .underrun(underrun)
  );

  text_pixel_serializer #(.FETCH_LATENCY(10), .FG_COLOR(FG_S), .BG_COLOR(BG_S)) dut_slow (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start_s), .pix_ce(pix_ce_s),
    .de(de_s), .toggle_restart(toggle_restart_s), .toggle_next(toggle_next_s),
    .cur_pixels(8'hFF), .pixel_on(pixel_on_s), .rgb(rgb_s), .underrun(underrun_s)
  );

  // generator model: char index resets on restart flip, advances on next flip
  logic       use_pat;
  logic [7:0] pat [4];
  logic [7:0] idx;
  logic       tr_prev, tn_prev, tn_s_prev;
  int         tn_cnt, tn_s_cnt;

  assign cur_pixels = use_pat ? pat[idx[1:0]] : idx;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tr_prev   <= 1'b0;
      tn_prev   <= 1'b0;
      tn_s_prev <= 1'b0;
      idx       <= 8'd0;
      tn_cnt    <= 0;
      tn_s_cnt  <= 0;
    end else begin
      tr_prev   <= toggle_restart;
      tn_prev   <= toggle_next;
      tn_s_prev <= toggle_next_s;
      if (toggle_restart != tr_prev) idx <= 8'd0;
      else if (toggle_next != tn_prev) idx <= idx + 8'd1;
      if (toggle_next != tn_prev) tn_cnt <= tn_cnt + 1;
      if (toggle_next_s != tn_s_prev) tn_s_cnt <= tn_s_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (6) step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    frame_start = 1'b0; pix_ce = 1'b0; de = 1'b0;
    frame_start_s = 1'b0; pix_ce_s = 1'b0; de_s = 1'b0;
    use_pat = 1'b0;
    #22;
    n_cmp++;
    if ({toggle_restart, toggle_next, pixel_on, underrun} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 0000", {toggle_restart, toggle_next, pixel_on, underrun});
    end
    n_cmp++;
    if (rgb !== BG) begin
      n_bad++;
      $display("FAIL reset_rgb: got %h want %h", rgb, BG);
    end
    n_cmp++;
    if (rgb_s !== BG_S) begin
      n_bad++;
      $display("FAIL reset_rgb_slow: got %h want %h", rgb_s, BG_S);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_restart();
    use_pat = 1'b0;
    @(negedge clk);
    frame_start = 1'b1;
    step();
    n_cmp++;
    if (toggle_restart !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_flip: got %b want 1", toggle_restart);
    end
    @(negedge clk);
    frame_start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_cmp++;
      if (dut.hold_valid_q !== (k == 4)) begin
        n_bad++;
        $display("FAIL restart_capture_t%0d: got %b want %b", k, dut.hold_valid_q, (k == 4));
      end
    end
    n_cmp++;
    if (dut.holding_q !== 8'h00) begin
      n_bad++;
      $display("FAIL restart_holding: got %h want 00", dut.holding_q);
    end
    n_cmp++;
    if (toggle_next !== 1'b0) begin
      n_bad++;
      $display("FAIL restart_no_next: got %b want 0", toggle_next);
    end
  endtask

  task automatic test_shift();
    logic [15:0] exp_seq;
    int tn0;
    exp_seq = 16'hA53C;
    use_pat = 1'b1;
    start_frame();
    tn0 = tn_cnt;
    @(negedge clk);
    pix_ce = 1'b1; de = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      n_cmp++;
      if (pixel_on !== exp_seq[15-i]) begin
        n_bad++;
        $display("FAIL shift_pixel_%0d: got %b want %b", i, pixel_on, exp_seq[15-i]);
      end
      n_cmp++;
      if (rgb !== (exp_seq[15-i] ? FG : BG)) begin
        n_bad++;
        $display("FAIL shift_rgb_%0d: got %h want %h", i, rgb, (exp_seq[15-i] ? FG : BG));
      end
    end
    @(negedge clk);
    pix_ce = 1'b0; de = 1'b0;
    repeat (2) step();
    n_cmp++;
    if (tn_cnt - tn0 !== 2) begin
      n_bad++;
      $display("FAIL shift_toggle_count: got %0d want 2", tn_cnt - tn0);
    end
  endtask

  task automatic pix2(input logic v);
    @(negedge clk);
    pix_ce = 1'b1; de = v;
    step();
    @(negedge clk);
    pix_ce = 1'b0;
    step();
  endtask

  task automatic test_frame();
    int tn0;
    use_pat = 1'b0;
    start_frame();
    tn0 = tn_cnt;
    for (int line = 0; line < 16; line++) begin
      for (int p = 0; p < 480; p++) pix2(1'b1);
      for (int p = 0; p < 80; p++) begin
        pix2(1'b0);
        n_cmp++;
        if (pixel_on !== 1'b0) begin
          n_bad++;
          $display("FAIL frame_blank_l%0d_p%0d: got %b want 0", line, p, pixel_on);
        end
      end
    end
    repeat (3) step();
    n_cmp++;
    if (tn_cnt - tn0 !== 960) begin
      n_bad++;
      $display("FAIL frame_toggle_count: got %0d want 960", tn_cnt - tn0);
    end
    n_cmp++;
    if (underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_underrun: got %b want 0", underrun);
    end
  endtask

  task automatic test_underrun();
    int tn0;
    @(negedge clk);
    frame_start_s = 1'b1;
    @(negedge clk);
    frame_start_s = 1'b0;
    repeat (12) step();
    tn0 = tn_s_cnt;
    @(negedge clk);
    pix_ce_s = 1'b1; de_s = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      n_cmp++;
      if (pixel_on_s !== (i < 8)) begin
        n_bad++;
        $display("FAIL underrun_pixel_%0d: got %b want %b", i, pixel_on_s, (i < 8));
      end
      n_cmp++;
      if (rgb_s !== ((i < 8) ? FG_S : BG_S)) begin
        n_bad++;
        $display("FAIL underrun_rgb_%0d: got %h want %h", i, rgb_s, ((i < 8) ? FG_S : BG_S));
      end
      if (i == 7 || i == 8) begin
        n_cmp++;
        if (underrun_s !== (i == 8)) begin
          n_bad++;
          $display("FAIL underrun_flag_%0d: got %b want %b", i, underrun_s, (i == 8));
        end
      end
    end
    @(negedge clk);
    pix_ce_s = 1'b0; de_s = 1'b0;
    repeat (2) step();
    n_cmp++;
    if (tn_s_cnt - tn0 !== 2) begin
      n_bad++;
      $display("FAIL underrun_toggle_count: got %0d want 2", tn_s_cnt - tn0);
    end
  endtask

  task automatic test_fs_on_load();
    logic tr0, tn0;
    int   cnt0;
    use_pat = 1'b1;
    start_frame();
    @(negedge clk);
    pix_ce = 1'b1; de = 1'b1;
    repeat (8) step();
    @(negedge clk);
    frame_start = 1'b1;
    tr0 = toggle_restart;
    tn0 = toggle_next;
    cnt0 = tn_cnt;
    step();
    n_cmp++;
    if (toggle_restart !== ~tr0) begin
      n_bad++;
      $display("FAIL fsload_restart: got %b want %b", toggle_restart, ~tr0);
    end
    n_cmp++;
    if (toggle_next !== tn0) begin
      n_bad++;
      $display("FAIL fsload_next_held: got %b want %b", toggle_next, tn0);
    end
    n_cmp++;
    if (dut.bit_cnt_q !== 3'd0) begin
      n_bad++;
      $display("FAIL fsload_bit_cnt: got %0d want 0", dut.bit_cnt_q);
    end
    @(negedge clk);
    frame_start = 1'b0; pix_ce = 1'b0; de = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) step();
      else step();
      n_cmp++;
      if (dut.hold_valid_q !== (k == 4)) begin
        n_bad++;
        $display("FAIL fsload_capture_t%0d: got %b want %b", k, dut.hold_valid_q, (k == 4));
      end
    end
    n_cmp++;
    if (tn_cnt - cnt0 !== 0) begin
      n_bad++;
      $display("FAIL fsload_no_next_flip: got %0d want 0", tn_cnt - cnt0);
    end
    @(negedge clk);
    pix_ce = 1'b1; de = 1'b1;
    step();
    n_cmp++;
    if (pixel_on !== 1'b1 || toggle_next !== ~tn0) begin
      n_bad++;
      $display("FAIL fsload_first_load: got on=%b next=%b want on=1 next=%b", pixel_on, toggle_next, ~tn0);
    end
    @(negedge clk);
    pix_ce = 1'b0; de = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    use_pat = 1'b1;
    start_frame();
    @(negedge clk);
    pix_ce = 1'b1; de = 1'b1;
    repeat (3) step();
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({toggle_restart, toggle_next, pixel_on, underrun} !== 4'b0000) begin
      n_bad++;
      $display("FAIL areset_outputs: got %b want 0000", {toggle_restart, toggle_next, pixel_on, underrun});
    end
    n_cmp++;
    if (rgb !== BG) begin
      n_bad++;
      $display("FAIL areset_rgb: got %h want %h", rgb, BG);
    end
    n_cmp++;
    if (underrun_s !== 1'b0) begin
      n_bad++;
      $display("FAIL areset_underrun_slow: got %b want 0", underrun_s);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++;
      if ({toggle_restart, toggle_next, pixel_on} !== 3'b000) begin
        n_bad++;
        $display("FAIL areset_idle_%0d: got %b want 000", i, {toggle_restart, toggle_next, pixel_on});
      end
    end
    @(negedge clk);
    pix_ce = 1'b0; de = 1'b0; frame_start = 1'b1;
    step();
    n_cmp++;
    if (toggle_restart !== 1'b1) begin
      n_bad++;
      $display("FAIL areset_restart: got %b want 1", toggle_restart);
    end
    @(negedge clk);
    frame_start = 1'b0;
    step();
  endtask

  initial begin
    pat[0] = 8'hA5; pat[1] = 8'h3C; pat[2] = 8'hFF; pat[3] = 8'h81;
    test_reset();
    test_restart();
    test_shift();
    test_frame();
    test_underrun();
    test_fs_on_load();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
